// File: rtl/wave_fetch_requester.sv
`default_nettype none
// ============================================================================
// Module   : wave_fetch_requester
// Purpose  : Initiator side of the instruction-buffer fetch interface. Keeps a
//            PC and fetch state per wavefront slot, round-robin arbitrates
//            among READY slots, issues registered one-cycle fetch requests and
//            routes returning instructions to decode tagged with wfid and PC.
// Options  : FETCH_TIMEOUT_EN - when defined, every in-flight request carries
//            a saturating age counter; a request older than TIMEOUT_CYC is
//            abandoned, fetch_err is raised and the slot goes back to READY.
// Revision : 1.0 - initial release
// ============================================================================
module wave_fetch_requester #(
    parameter int NUM_WF          = 40,
    parameter int WFID_W          = 6,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYC     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_valid,
    input  logic [WFID_W-1:0] dispatch_wfid,
    input  logic [31:0]       dispatch_pc,
    input  logic              issue_done_valid,
    input  logic [WFID_W-1:0] issue_done_wfid,
    input  logic              issue_done_redirect,
    input  logic [31:0]       issue_done_pc,
    input  logic              issue_done_halt,
    output logic              fetch_rd_en,
    output logic [31:0]       fetch_addr,
    output logic [38:0]       fetch_tag,
    input  logic              fetchwave_ack,
    input  logic [31:0]       wave_instr,
    input  logic [38:0]       wave_tag,
    output logic              instr_valid,
    output logic [31:0]       instr_out,
    output logic [WFID_W-1:0] instr_wfid,
    output logic [31:0]       instr_pc,
    output logic              fetch_err,
    output logic [3:0]        outstanding
);

    // Per-slot fetch state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Slot state and PCs
    logic [1:0]        state_q [NUM_WF];
    logic [1:0]        state_d [NUM_WF];
    logic [31:0]       pc_q    [NUM_WF];
    logic [31:0]       pc_d    [NUM_WF];

    // Shared control and registered outputs
    logic [WFID_W-1:0] rr_q, rr_d;
    logic [3:0]        outstanding_q, outstanding_d;
    logic              fetch_err_q, fetch_err_d;
    logic              fetch_rd_en_q, fetch_rd_en_d;
    logic [31:0]       fetch_addr_q, fetch_addr_d;
    logic [38:0]       fetch_tag_q, fetch_tag_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_out_q, instr_out_d;
    logic [WFID_W-1:0] instr_wfid_q, instr_wfid_d;
    logic [31:0]       instr_pc_q, instr_pc_d;

    // Decoded events for this cycle
    logic              gnt_vld;
    logic [WFID_W-1:0] gnt_id;
    logic [WFID_W-1:0] ack_wfid;
    logic              disp_ok;
    logic              done_ok;
    logic              ack_ok;
    logic              proto_err;
    logic              to_fire;
    logic [WFID_W-1:0] to_wfid;

    // Bit 6 of the echoed tag is a fixed zero separator and carries no data
    logic              unused_tag_sep;
    assign unused_tag_sep = wave_tag[6];

    // Round-robin arbiter: first READY slot at or after rr pointer, gated by credit
    always_comb begin
        int                idx;
        logic [WFID_W-1:0] idx_w;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        idx_w   = '0;
        if (int'(outstanding_q) < MAX_OUTSTANDING) begin
            for (int i = 0; i < NUM_WF; i++) begin
                idx = int'(rr_q) + i;
                if (idx >= NUM_WF) begin
                    idx = idx - NUM_WF;
                end
                idx_w = WFID_W'(idx);
                if (!gnt_vld && (state_q[idx_w] == ST_READY)) begin
                    gnt_vld = 1'b1;
                    gnt_id  = idx_w;
                end
            end
        end
    end

    // Qualify dispatch / issue_done / ack against the current slot state
    always_comb begin
        ack_wfid  = wave_tag[WFID_W-1:0];
        disp_ok   = dispatch_valid && (int'(dispatch_wfid) < NUM_WF) &&
                    (state_q[dispatch_wfid] == ST_IDLE);
        done_ok   = issue_done_valid && (int'(issue_done_wfid) < NUM_WF) &&
                    (state_q[issue_done_wfid] == ST_HOLD);
        ack_ok    = fetchwave_ack && (int'(ack_wfid) < NUM_WF) &&
                    (state_q[ack_wfid] == ST_WAIT) && (outstanding_q != 4'd0);
        proto_err = (dispatch_valid && !disp_ok) ||
                    (issue_done_valid && !done_ok) ||
                    (fetchwave_ack && !ack_ok);
    end

`ifdef FETCH_TIMEOUT_EN
    // One age-tracking entry per possible in-flight request
    localparam int AGE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT_CYC);

    logic              ent_vld_q  [MAX_OUTSTANDING];
    logic              ent_vld_d  [MAX_OUTSTANDING];
    logic [WFID_W-1:0] ent_wfid_q [MAX_OUTSTANDING];
    logic [WFID_W-1:0] ent_wfid_d [MAX_OUTSTANDING];
    logic [AGE_W-1:0]  ent_age_q  [MAX_OUTSTANDING];
    logic [AGE_W-1:0]  ent_age_d  [MAX_OUTSTANDING];

    // Age entries, pick one expired request per cycle, free on ack/timeout, allocate on grant
    always_comb begin
        logic alloc_done;
        alloc_done = 1'b0;
        to_fire    = 1'b0;
        to_wfid    = '0;
        for (int e = 0; e < MAX_OUTSTANDING; e++) begin
            if (!to_fire && ent_vld_q[e] && (ent_age_q[e] == AGE_MAX) &&
                !(ack_ok && (ent_wfid_q[e] == ack_wfid))) begin
                to_fire = 1'b1;
                to_wfid = ent_wfid_q[e];
            end
        end
        for (int e = 0; e < MAX_OUTSTANDING; e++) begin
            ent_vld_d[e]  = ent_vld_q[e];
            ent_wfid_d[e] = ent_wfid_q[e];
            ent_age_d[e]  = ent_age_q[e];
            if (ent_vld_q[e] && (ent_age_q[e] != AGE_MAX)) begin
                ent_age_d[e] = ent_age_q[e] + AGE_W'(1);
            end
            if (ent_vld_q[e] && ack_ok && (ent_wfid_q[e] == ack_wfid)) begin
                ent_vld_d[e] = 1'b0;
            end
            if (ent_vld_q[e] && to_fire && (ent_wfid_q[e] == to_wfid)) begin
                ent_vld_d[e] = 1'b0;
            end
        end
        for (int e = 0; e < MAX_OUTSTANDING; e++) begin
            if (gnt_vld && !alloc_done && !ent_vld_q[e]) begin
                ent_vld_d[e]  = 1'b1;
                ent_wfid_d[e] = gnt_id;
                ent_age_d[e]  = '0;
                alloc_done    = 1'b1;
            end
        end
    end

    // Age table registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < MAX_OUTSTANDING; e++) begin
                ent_vld_q[e]  <= 1'b0;
                ent_wfid_q[e] <= '0;
                ent_age_q[e]  <= '0;
            end
        end else begin
            for (int e = 0; e < MAX_OUTSTANDING; e++) begin
                ent_vld_q[e]  <= ent_vld_d[e];
                ent_wfid_q[e] <= ent_wfid_d[e];
                ent_age_q[e]  <= ent_age_d[e];
            end
        end
    end
`else
    assign to_fire = 1'b0;
    assign to_wfid = '0;
`endif

    // Next slot state; events target distinct states so they never collide on one slot
    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            state_d[i] = state_q[i];
        end
        if (gnt_vld) begin
            state_d[gnt_id] = ST_WAIT;
        end
        if (ack_ok) begin
            state_d[ack_wfid] = ST_HOLD;
        end
        if (to_fire) begin
            state_d[to_wfid] = ST_READY;
        end
        if (disp_ok) begin
            state_d[dispatch_wfid] = ST_READY;
        end
        if (done_ok) begin
            state_d[issue_done_wfid] = issue_done_halt ? ST_IDLE : ST_READY;
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        for (int i = 0; i < NUM_WF; i++) begin
            pc_d[i] = pc_q[i];
        end
        if (disp_ok) begin
            pc_d[dispatch_wfid] = dispatch_pc;
        end
        if (done_ok && !issue_done_halt) begin
            pc_d[issue_done_wfid] = issue_done_redirect ? issue_done_pc
                                                        : pc_q[issue_done_wfid] + 32'd4;
        end

        rr_d          = rr_q;
        fetch_rd_en_d = gnt_vld;
        fetch_addr_d  = fetch_addr_q;
        fetch_tag_d   = fetch_tag_q;
        if (gnt_vld) begin
            rr_d         = (int'(gnt_id) == NUM_WF - 1) ? '0 : gnt_id + WFID_W'(1);
            fetch_addr_d = pc_q[gnt_id];
            fetch_tag_d  = {pc_q[gnt_id], 1'b0, 6'(gnt_id)};
        end

        instr_valid_d = ack_ok;
        instr_out_d   = instr_out_q;
        instr_wfid_d  = instr_wfid_q;
        instr_pc_d    = instr_pc_q;
        if (ack_ok) begin
            instr_out_d  = wave_instr;
            instr_wfid_d = ack_wfid;
            instr_pc_d   = wave_tag[38:7];
        end

        // Accepted acks and timeouts each retire a request that was counted in
        outstanding_d = outstanding_q + {3'd0, gnt_vld} - {3'd0, ack_ok} - {3'd0, to_fire};
        fetch_err_d   = fetch_err_q | proto_err | to_fire;
    end

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_WF; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // PC, arbitration pointer, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                pc_q[i] <= '0;
            end
            rr_q          <= '0;
            outstanding_q <= '0;
            fetch_err_q   <= 1'b0;
            fetch_rd_en_q <= 1'b0;
            fetch_addr_q  <= '0;
            fetch_tag_q   <= '0;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_wfid_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_WF; i++) begin
                pc_q[i] <= pc_d[i];
            end
            rr_q          <= rr_d;
            outstanding_q <= outstanding_d;
            fetch_err_q   <= fetch_err_d;
            fetch_rd_en_q <= fetch_rd_en_d;
            fetch_addr_q  <= fetch_addr_d;
            fetch_tag_q   <= fetch_tag_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_wfid_q  <= instr_wfid_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign fetch_rd_en = fetch_rd_en_q;
    assign fetch_addr  = fetch_addr_q;
    assign fetch_tag   = fetch_tag_q;
    assign instr_valid = instr_valid_q;
    assign instr_out   = instr_out_q;
    assign instr_wfid  = instr_wfid_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;
    assign outstanding = outstanding_q;

endmodule
`default_nettype wire

// File: tb/tb_wave_fetch_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_fetch_requester
// Purpose  : Self-checking bench for wave_fetch_requester: directed scenarios
//            with literal expectations plus randomized traffic compared every
//            cycle against a behavioural model of the slot rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_fetch_requester;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;
    localparam int MAXO   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              dispatch_valid;
    logic [WFID_W-1:0] dispatch_wfid;
    logic [31:0]       dispatch_pc;
    logic              issue_done_valid;
    logic [WFID_W-1:0] issue_done_wfid;
    logic              issue_done_redirect;
    logic [31:0]       issue_done_pc;
    logic              issue_done_halt;
    logic              fetch_rd_en;
    logic [31:0]       fetch_addr;
    logic [38:0]       fetch_tag;
    logic              fetchwave_ack;
    logic [31:0]       wave_instr;
    logic [38:0]       wave_tag;
    logic              instr_valid;
    logic [31:0]       instr_out;
    logic [WFID_W-1:0] instr_wfid;
    logic [31:0]       instr_pc;
    logic              fetch_err;
    logic [3:0]        outstanding;

    wave_fetch_requester #(
        .NUM_WF(NUM_WF), .WFID_W(WFID_W), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_wfid(dispatch_wfid), .dispatch_pc(dispatch_pc),
        .issue_done_valid(issue_done_valid), .issue_done_wfid(issue_done_wfid),
        .issue_done_redirect(issue_done_redirect), .issue_done_pc(issue_done_pc),
        .issue_done_halt(issue_done_halt),
        .fetch_rd_en(fetch_rd_en), .fetch_addr(fetch_addr), .fetch_tag(fetch_tag),
        .fetchwave_ack(fetchwave_ack), .wave_instr(wave_instr), .wave_tag(wave_tag),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_wfid(instr_wfid),
        .instr_pc(instr_pc), .fetch_err(fetch_err), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int pulses = 0;
    int gq[$];

    // Behavioural model: slot status 0 idle, 1 ready, 2 awaiting ack, 3 holding
    int          m_st [NUM_WF];
    logic [31:0] m_pc [NUM_WF];
    int          m_rr;
    int          m_out;
    bit          m_err;
    logic        e_rd_en;
    logic [31:0] e_addr;
    logic [38:0] e_tag;
    logic        e_iv;
    logic [31:0] e_iout;
    logic [5:0]  e_iwf;
    logic [31:0] e_ipc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Predict what the DUT will show after the coming clock edge
    function automatic void model_step();
        int g;
        int aw;
        int dw;
        int cw;
        bit d_ok;
        bit c_ok;
        bit a_ok;
        if (rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                m_st[i] = 0;
                m_pc[i] = 32'd0;
            end
            m_rr = 0; m_out = 0; m_err = 1'b0;
            e_rd_en = 1'b0; e_addr = '0; e_tag = '0;
            e_iv = 1'b0; e_iout = '0; e_iwf = '0; e_ipc = '0;
            return;
        end
        g = -1;
        if (m_out < MAXO) begin
            for (int i = 0; i < NUM_WF; i++) begin
                if (m_st[(m_rr + i) % NUM_WF] == 1) begin
                    g = (m_rr + i) % NUM_WF;
                    break;
                end
            end
        end
        aw = int'(wave_tag[5:0]);
        dw = int'(dispatch_wfid);
        cw = int'(issue_done_wfid);
        a_ok = fetchwave_ack && (aw < NUM_WF) && (m_out > 0) && (m_st[aw % NUM_WF] == 2);
        d_ok = dispatch_valid && (dw < NUM_WF) && (m_st[dw % NUM_WF] == 0);
        c_ok = issue_done_valid && (cw < NUM_WF) && (m_st[cw % NUM_WF] == 3);
        if ((dispatch_valid && !d_ok) || (issue_done_valid && !c_ok) || (fetchwave_ack && !a_ok))
            m_err = 1'b1;
        e_rd_en = (g >= 0);
        if (g >= 0) begin
            e_addr  = m_pc[g];
            e_tag   = {m_pc[g], 1'b0, 6'(g)};
            m_st[g] = 2;
            m_rr    = (g + 1) % NUM_WF;
            m_out   = m_out + 1;
        end
        e_iv = a_ok;
        if (a_ok) begin
            e_iout   = wave_instr;
            e_iwf    = wave_tag[5:0];
            e_ipc    = wave_tag[38:7];
            m_st[aw] = 3;
            m_out    = m_out - 1;
        end
        if (d_ok) begin
            m_st[dw] = 1;
            m_pc[dw] = dispatch_pc;
        end
        if (c_ok) begin
            if (issue_done_halt) m_st[cw] = 0;
            else begin
                m_st[cw] = 1;
                m_pc[cw] = issue_done_redirect ? issue_done_pc : m_pc[cw] + 32'd4;
            end
        end
    endfunction

    // Every cycle: DUT outputs against the model's prediction
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("fetch_rd_en", 64'(fetch_rd_en), 64'(e_rd_en));
            chk("fetch_addr", 64'(fetch_addr), 64'(e_addr));
            chk("fetch_tag", 64'(fetch_tag), 64'(e_tag));
            chk("instr_valid", 64'(instr_valid), 64'(e_iv));
            chk("instr_out", 64'(instr_out), 64'(e_iout));
            chk("instr_wfid", 64'(instr_wfid), 64'(e_iwf));
            chk("instr_pc", 64'(instr_pc), 64'(e_ipc));
            chk("fetch_err", 64'(fetch_err), 64'(m_err));
            chk("outstanding", 64'(outstanding), 64'(m_out));
        end
    end

    task automatic idle_inputs();
        dispatch_valid = 1'b0; dispatch_wfid = '0; dispatch_pc = '0;
        issue_done_valid = 1'b0; issue_done_wfid = '0; issue_done_redirect = 1'b0;
        issue_done_pc = '0; issue_done_halt = 1'b0;
        fetchwave_ack = 1'b0; wave_instr = '0; wave_tag = '0;
        rst = 1'b0;
    endtask

    // Apply the driven inputs for one edge, then observe at the next falling edge
    task automatic tick();
        model_step();
        @(negedge clk);
        idle_inputs();
        if (fetch_rd_en === 1'b1) begin
            pulses++;
            gq.push_back(int'(fetch_tag[5:0]));
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b1;
            tick();
        end
    endtask

    task automatic dispatch(input int w, input logic [31:0] pc);
        dispatch_valid = 1'b1; dispatch_wfid = 6'(w); dispatch_pc = pc;
        tick();
    endtask

    task automatic ack(input int w, input logic [31:0] instr);
        fetchwave_ack = 1'b1; wave_instr = instr; wave_tag = {m_pc[w], 1'b0, 6'(w)};
        tick();
    endtask

    task automatic done(input int w, input bit redir, input logic [31:0] pc, input bit halt);
        issue_done_valid = 1'b1; issue_done_wfid = 6'(w);
        issue_done_redirect = redir; issue_done_pc = pc; issue_done_halt = halt;
        tick();
    endtask

    function automatic int pick(input int st, input int p_legal, input int fallback);
        int cand[$];
        for (int i = 0; i < NUM_WF; i++) if (m_st[i] == st) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(0, 99) < p_legal)
            return cand[$urandom_range(0, cand.size() - 1)];
        return fallback;
    endfunction

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        do_reset(3);
        chk_en = 1'b1;
        chk("reset_rd_en", 64'(fetch_rd_en), 64'd0);
        chk("reset_err", 64'(fetch_err), 64'd0);
        chk("reset_outstanding", 64'(outstanding), 64'd0);
        chk("reset_addr", 64'(fetch_addr), 64'd0);

        // Basic fetch round trip with registered request and response
        dispatch(2, 32'h4);
        chk("t1_no_req_yet", 64'(fetch_rd_en), 64'd0);
        tick();
        chk("t1_rd_en", 64'(fetch_rd_en), 64'd1);
        chk("t1_addr", 64'(fetch_addr), 64'h4);
        chk("t1_tag", 64'(fetch_tag), 64'h202);
        chk("t1_outst", 64'(outstanding), 64'd1);
        tick();
        chk("t1_pulse_width", 64'(fetch_rd_en), 64'd0);
        ack(2, 32'h0D0C0B0A);
        chk("t1_iv", 64'(instr_valid), 64'd1);
        chk("t1_iout", 64'(instr_out), 64'h0D0C0B0A);
        chk("t1_iwf", 64'(instr_wfid), 64'd2);
        chk("t1_ipc", 64'(instr_pc), 64'h4);
        tick();
        chk("t1_iv_width", 64'(instr_valid), 64'd0);

        // Redirect, then halt
        done(2, 1'b1, 32'h100, 1'b0);
        tick();
        chk("t4_redirect_addr", 64'(fetch_addr), 64'h100);
        ack(2, 32'h11223344);
        chk("t4_ipc", 64'(instr_pc), 64'h100);
        done(2, 1'b0, 32'h0, 1'b1);
        pulses = 0;
        repeat (5) tick();
        chk("t4_halt_no_req", 64'(pulses), 64'd0);
        chk("t4_err_clean", 64'(fetch_err), 64'd0);

        // Credit limit
        do_reset(1);
        pulses = 0;
        for (int k = 0; k < 6; k++) dispatch(10 + k, 32'h1000 + 32'(k * 16));
        repeat (4) tick();
        chk("t3_req_count", 64'(pulses), 64'd4);
        chk("t3_outst_full", 64'(outstanding), 64'd4);
        ack(10, 32'hA5A5A5A5);
        repeat (2) tick();
        chk("t3_req_after_ack", 64'(pulses), 64'd5);
        chk("t3_outst_still", 64'(outstanding), 64'd4);

        // Round-robin order and pointer wrap
        do_reset(1);
        gq.delete();
        dispatch(0, 32'h40); dispatch(1, 32'h80); dispatch(39, 32'hC0);
        repeat (2) tick();
        chk("t2_n", 64'(gq.size()), 64'd3);
        if (gq.size() == 3) begin
            chk("t2_first", 64'(gq[0]), 64'd0);
            chk("t2_second", 64'(gq[1]), 64'd1);
            chk("t2_third", 64'(gq[2]), 64'd39);
        end
        ack(0, 32'h1); ack(1, 32'h2); ack(39, 32'h3);
        done(39, 1'b0, 32'h0, 1'b1);
        dispatch(36, 32'h200); dispatch(37, 32'h204); dispatch(38, 32'h208); dispatch(39, 32'h20C);
        repeat (2) tick();
        chk("t2_full", 64'(outstanding), 64'd4);
        done(1, 1'b0, 32'h0, 1'b0);
        done(0, 1'b0, 32'h0, 1'b0);
        repeat (2) tick();
        chk("t2_blocked", 64'(gq.size()), 64'd7);
        ack(36, 32'h5); tick();
        ack(37, 32'h6); tick();
        chk("t2_n2", 64'(gq.size()), 64'd9);
        if (gq.size() == 9) begin
            chk("t2_wrap_first", 64'(gq[7]), 64'd0);
            chk("t2_wrap_second", 64'(gq[8]), 64'd1);
        end
        chk("t2_pc_inc", 64'(m_pc[0]), 64'h44);

        // Stray ack to an idle slot
        do_reset(1);
        fetchwave_ack = 1'b1; wave_instr = 32'hDEAD; wave_tag = {32'h0, 1'b0, 6'd5};
        tick();
        chk("t5_no_iv", 64'(instr_valid), 64'd0);
        chk("t5_err", 64'(fetch_err), 64'd1);
        repeat (5) tick();
        chk("t5_err_sticky", 64'(fetch_err), 64'd1);
        do_reset(1);
        chk("t5_err_cleared", 64'(fetch_err), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
            end else begin
                if ($urandom_range(0, 99) < 30) begin
                    dispatch_valid = 1'b1;
                    dispatch_wfid  = 6'(pick(0, 97, $urandom_range(0, 63)));
                    dispatch_pc    = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
                end
                if ($urandom_range(0, 99) < 35) begin
                    issue_done_valid    = 1'b1;
                    issue_done_wfid     = 6'(pick(3, 97, $urandom_range(0, 63)));
                    issue_done_redirect = 1'($urandom_range(0, 1));
                    issue_done_halt     = ($urandom_range(0, 4) == 0);
                    issue_done_pc       = $urandom() & 32'hFFFFFFFC;
                end
                if ($urandom_range(0, 99) < 40) begin
                    int w;
                    w = pick(2, 98, $urandom_range(0, 63));
                    fetchwave_ack = 1'b1;
                    wave_instr    = $urandom();
                    wave_tag      = (w < NUM_WF) ? {m_pc[w], 1'b0, 6'(w)} : {$urandom(), 1'b0, 6'(w)};
                end
            end
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish t=%0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/wave_fetch_requester.md
Name: wave_fetch_requester

Overview:
Initiator side of the instruction-buffer fetch interface. Holds a PC and fetch state per wavefront and round-robin arbitrates among ready wavefronts. Issues one-cycle fetch_rd_en pulses with address and tag, and matches returning fetchwave_ack/wave_tag to the owning wavefront. Sits between wavefront dispatch/issue and the instruction buffer; fetched words are forwarded to decode tagged with wavefront ID and PC.

Parameters:
NUM_WF, 40, number of wavefront slots (IDs 0..NUM_WF-1)
WFID_W, 6, wavefront ID width
MAX_OUTSTANDING, 4, max fetches in flight across all wavefronts (1..15)
TIMEOUT_CYC, 255, watchdog limit in cycles (used only with optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
dispatch_valid  in  1  start a wavefront
dispatch_wfid  in  WFID_W  wavefront being started
dispatch_pc  in  32  initial PC, word aligned
issue_done_valid  in  1  decode finished with the wavefront's last instruction
issue_done_wfid  in  WFID_W  wavefront concerned
issue_done_redirect  in  1  1: next PC = issue_done_pc; 0: PC+4
issue_done_pc  in  32  branch target
issue_done_halt  in  1  wavefront ends (s_endpgm); slot returns to IDLE
fetch_rd_en  out  1  one-cycle fetch request
fetch_addr  out  32  byte address, = wavefront PC
fetch_tag  out  39  {pc[31:0], 1'b0, wfid[5:0]}
fetchwave_ack  in  1  response valid
wave_instr  in  32  fetched instruction
wave_tag  in  39  echoed tag
instr_valid  out  1  instruction to decode
instr_out  out  32  instruction word
instr_wfid  out  WFID_W  owner (= wave_tag[5:0])
instr_pc  out  32  PC (= wave_tag[38:7])
fetch_err  out  1  sticky protocol error
outstanding  out  4  fetches in flight

Behaviour:
- Reset (rst=1 at edge): all slots IDLE, PCs 0, rr pointer 0, outstanding=0. fetch_rd_en, instr_valid and fetch_err are 0. fetch_addr, fetch_tag, instr_out, instr_wfid and instr_pc are 0. Reset mid-flight discards all in-flight state. Acks arriving after reset deassertion whose slot is not WAIT_ACK set fetch_err.
- Per-slot states: IDLE -> READY (dispatch) -> WAIT_ACK (granted) -> HOLD (ack received) -> READY (issue_done, not halt) or IDLE (issue_done with halt).
- Dispatch to non-IDLE slot: ignored, fetch_err set.
- Arbitration: combinational over READY slots, round-robin starting at rr pointer. Grant only if outstanding < MAX_OUTSTANDING. On grant, rr pointer = granted wfid+1 (wraps at NUM_WF-1 -> 0).
- Request outputs are registered. A slot dispatched at edge N becomes READY. It is granted in cycle N+1, and fetch_rd_en=1 in cycle N+2 for exactly one cycle. fetch_addr/fetch_tag are valid only while fetch_rd_en=1 and hold their value otherwise. At most one request per cycle; back-to-back requests are allowed.
- Response: on fetchwave_ack, wfid = wave_tag[5:0]. If that slot is WAIT_ACK, it moves to HOLD and the instruction is forwarded registered: instr_valid=1 on the next cycle, one cycle wide. Otherwise the response is dropped and fetch_err is set.
- outstanding: +1 on grant, -1 on accepted ack, unchanged if both occur in the same cycle. An ack with outstanding=0 sets fetch_err and does not underflow.
- issue_done: slot in HOLD only. PC += 4 (32-bit wrap 0xFFFFFFFC -> 0) or PC = issue_done_pc if redirect; halt wins over redirect. issue_done to a non-HOLD slot sets fetch_err and is ignored.
- dispatch and issue_done to different slots in the same cycle are both applied. For the same slot, the dispatch is the error case.
- fetch_err clears only on reset.

Optional Feature:
FETCH_TIMEOUT_EN: defined -> per-request age counter, one per in-flight request, saturating. If any in-flight request exceeds TIMEOUT_CYC cycles without an ack, fetch_err is set and the owning slot returns to READY for reissue. outstanding is decremented at that point, and a late ack for that slot is then treated as an error. Undefined -> no counters, no timeout; requests wait indefinitely.

Test Plan:
1. Reset 3 cycles, dispatch wfid=2 pc=0x4 -> fetch_rd_en one cycle later-by-one (N+2), fetch_addr=0x00000004, fetch_tag={0x00000004,0,6'd2}; ack with instr 0x0D0C0B0A -> instr_valid next cycle, instr_out=0x0D0C0B0A, instr_wfid=2, instr_pc=0x4.
2. Dispatch wfids 0,1,39 same-cycle-sequenced, no acks -> requests issued in order 0,1,39. Then pointer wraps: redispatch after done grants 0 before 1.
3. Dispatch 6 wavefronts, withhold acks -> exactly 4 requests, outstanding=4. One ack -> fifth request issued, outstanding stays 4.
4. issue_done redirect=1 pc=0x100 for wfid=2 in HOLD -> next fetch_addr=0x100. Then issue_done halt=1 -> slot IDLE, no further requests.
5. Ack with wave_tag wfid=5 while slot 5 IDLE -> no instr_valid, fetch_err=1 sticky until rst.
6. With FETCH_TIMEOUT_EN, TIMEOUT_CYC=8, never ack -> fetch_err=1, request for same wfid reissued, outstanding unchanged by reissue net.
